// File: rtl/ka_193bit_seq_ctrl.sv
// Iterative 193x193 GF(2) multiplier: one 97x97 carry-less core reused for the
// low, high and middle Karatsuba products, XOR-accumulated into a 385-bit result.

module ka_97bit (
    input  logic [96:0]  a,
    input  logic [96:0]  b,
    output logic [192:0] p
);
    always_comb begin
        // NOTE: combinational outputs get a default first so no path infers a latch.
        p = '0;
        for (int i = 0; i < 97; i++) begin
            if (b[i]) p = p ^ ({96'b0, a} << i);
        end
    end
endmodule

module ka_193bit_seq_ctrl #(
    parameter int unsigned PIPE_MUL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [192:0] a_in,
    input  logic [192:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [384:0] y_out,
    output logic         busy
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_MID   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_LO   = 2'd1;
    localparam logic [1:0] TAG_HI   = 2'd2;
    localparam logic [1:0] TAG_MID  = 2'd3;

    logic [2:0]   state_q, state_d;
    logic [192:0] a_q, b_q;
    logic [384:0] acc_q;
    logic         accept;

    logic [96:0]  a_lo, a_hi, a_mid, b_lo, b_hi, b_mid;
    logic [96:0]  mul_a, mul_b;
    logic [192:0] prod, acc_prod;
    logic [1:0]   sel_tag, acc_tag;
    logic [384:0] prod_ext, contrib;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y_out     = acc_q;
    assign accept    = in_valid & in_ready;

    assign a_lo  = a_q[96:0];
    assign a_hi  = {1'b0, a_q[192:97]};
    assign a_mid = a_lo ^ a_hi;
    assign b_lo  = b_q[96:0];
    assign b_hi  = {1'b0, b_q[192:97]};
    assign b_mid = b_lo ^ b_hi;

    always_comb begin
        sel_tag = TAG_NONE;
        case (state_q)
            S_LO:    sel_tag = TAG_LO;
            S_HI:    sel_tag = TAG_HI;
            S_MID:   sel_tag = TAG_MID;
            default: sel_tag = TAG_NONE;
        endcase
    end

    always_comb begin
        mul_a = a_lo;
        mul_b = b_lo;
        case (sel_tag)
            TAG_HI:  begin mul_a = a_hi;  mul_b = b_hi;  end
            TAG_MID: begin mul_a = a_mid; mul_b = b_mid; end
            default: begin mul_a = a_lo;  mul_b = b_lo;  end
        endcase
    end

    ka_97bit u_ka (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // The product and its step tag travel together, so accumulation always
    // places a product according to the step that generated it.
    generate
        if (PIPE_MUL != 0) begin : g_pipe
            logic [192:0] prod_q;
            logic [1:0]   tag_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q <= '0;
                    tag_q  <= TAG_NONE;
                end else begin
                    prod_q <= prod;
                    tag_q  <= sel_tag;
                end
            end
            assign acc_prod = prod_q;
            assign acc_tag  = tag_q;
        end else begin : g_comb
            assign acc_prod = prod;
            assign acc_tag  = sel_tag;
        end
    endgenerate

    // High half has a zero top bit, so P2 << 194 never reaches past bit 384.
    assign prod_ext = {192'b0, acc_prod};

    always_comb begin
        contrib = '0;
        case (acc_tag)
            TAG_LO:  contrib = prod_ext ^ (prod_ext << 97);
            TAG_HI:  contrib = (prod_ext << 97) ^ (prod_ext << 194);
            TAG_MID: contrib = prod_ext << 97;
            default: contrib = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = S_LO;
            S_LO:    state_d = S_HI;
            S_HI:    state_d = S_MID;
            S_MID:   state_d = (PIPE_MUL != 0) ? S_DRAIN : DONE;
            S_DRAIN: state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, the wide accumulator included, is reset so an
        // aborted sequence can never leak a partial product onto y_out.
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            if (accept) begin
                a_q   <= a_in;
                b_q   <= b_in;
                acc_q <= '0;
            end else begin
                acc_q <= acc_q ^ contrib;
            end
        end
    end
endmodule

// File: tb/tb_ka_193bit_seq_ctrl.sv
// Directed table plus hand sequences (backpressure, reset abort) and a random
// run against a plain shift-and-XOR carry-less multiply model.

module tb_ka_193bit_seq_ctrl;
    localparam int unsigned PIPE_MUL = 0;
    localparam int LAT = 3 + int'(PIPE_MUL);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [192:0] a_in;
    logic [192:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [384:0] y_out;
    logic         busy;

    ka_193bit_seq_ctrl #(.PIPE_MUL(PIPE_MUL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [192:0] a;
        logic [192:0] b;
        logic [384:0] y;
        int           stall;
        bit           early;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [384:0] act, input logic [384:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [384:0] clmul(input logic [192:0] a, input logic [192:0] b);
        logic [384:0] r;
        r = '0;
        for (int i = 0; i < 193; i++) begin
            if (b[i]) r = r ^ ({192'b0, a} << i);
        end
        return r;
    endfunction

    function automatic logic [192:0] rnd193();
        logic [223:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[192:0];
    endfunction

    task automatic accept_op(input logic [192:0] a, input logic [192:0] b, input string name);
        @(negedge clk);
        check({name, "_in_ready"}, {384'b0, in_ready}, 385'd1);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = rnd193();
        b_in     = rnd193();
    endtask

    // Called right after the accept edge; returns at the negedge where out_valid is seen.
    task automatic wait_result(input logic [384:0] exp, input string name, input bit check_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, {384'b0, out_valid}, 385'd1);
        end else begin
            if (check_lat) check({name, "_latency"}, 385'(lat), 385'(LAT));
            check({name, "_y"}, y_out, exp);
        end
    endtask

    task automatic release_out(input logic [384:0] exp, input int stall, input string name);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({name, "_stall"}, {y_out, out_valid, busy}, {exp, 2'b11});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [192:0] a, input logic [192:0] b, input logic [384:0] exp,
                          input int stall, input bit early, input string name);
        accept_op(a, b, name);
        if (early) out_ready = 1'b1;
        wait_result(exp, name, 1'b1);
        release_out(exp, early ? 0 : stall, name);
    endtask

    initial begin
        logic [384:0] even_ones;
        logic [192:0] ones193;
        logic [192:0] na, nb;

        even_ones = '0;
        for (int i = 0; i <= 192; i++) even_ones[2*i] = 1'b1;
        ones193 = '1;

        vecs[0] = '{a: 193'd1,             b: 193'd1,             y: 385'd1,                 stall: 0, early: 1'b0};
        vecs[1] = '{a: 193'd1 << 97,       b: 193'd1,             y: 385'd1 << 97,           stall: 1, early: 1'b0};
        vecs[2] = '{a: 193'd1 << 96,       b: 193'd1 << 96,       y: 385'd1 << 192,          stall: 0, early: 1'b1};
        vecs[3] = '{a: 193'd1 << 192,      b: 193'd1 << 192,      y: 385'd1 << 384,          stall: 2, early: 1'b0};
        vecs[4] = '{a: ones193,            b: ones193,            y: even_ones,              stall: 0, early: 1'b0};
        vecs[5] = '{a: 193'd0,             b: ones193,            y: 385'd0,                 stall: 0, early: 1'b0};
        vecs[6] = '{a: (193'd1 << 97) | 1, b: (193'd1 << 97) | 1, y: (385'd1 << 194) | 1,    stall: 0, early: 1'b1};
        vecs[7] = '{a: 193'd3,             b: 193'd6,             y: 385'd10,                stall: 3, early: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #12;
        check("reset_ctrl", {382'b0, in_ready, out_valid, busy}, 385'b100);
        check("reset_y", y_out, 385'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].stall, vecs[i].early,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result, with ignored in_valid traffic, then overlap the handshake.
        na = rnd193();
        nb = rnd193();
        accept_op(na, nb, "bp");
        wait_result(clmul(na, nb), "bp", 1'b1);
        in_valid = 1'b1;
        a_in     = rnd193();
        b_in     = rnd193();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_hold_ctrl", {382'b0, out_valid, in_ready, busy}, 385'b101);
            check("bp_hold_y", y_out, clmul(na, nb));
        end
        out_ready = 1'b1;
        na = 193'h1_2345_6789;
        nb = 193'h9_8765_4321;
        a_in = na;
        b_in = nb;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_not_taken", {382'b0, in_ready, busy, out_valid}, 385'b100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        wait_result(clmul(na, nb), "bp_next", 1'b1);
        release_out(clmul(na, nb), 0, "bp_next");

        // Reset abort while the high product is being accumulated.
        accept_op(rnd193(), rnd193(), "rst");
        @(posedge clk);
        #1;
        check("rst_in_s_hi", {384'b0, busy}, 385'd1);
        rst_n = 1'b0;
        #1;
        check("rst_now_ctrl", {382'b0, in_ready, out_valid, busy}, 385'b100);
        check("rst_now_y", y_out, 385'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_ctrl", {382'b0, in_ready, out_valid, busy}, 385'b100);
        run_op(193'd3, 193'd3, 385'd5, 0, 1'b0, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [192:0] ra, rb;
            ra = rnd193();
            rb = rnd193();
            if ($urandom_range(0, 3) == 0) ra = ra & rnd193() & rnd193();
            run_op(ra, rb, clmul(ra, rb), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end
endmodule
